// File: rtl/snn_frame_loader.sv
// Frame loader for the SNN core: unpacks UART bytes LSB-first into a bit-wide RAM,
// starts the core once a frame is complete and hands the classified digit to UART TX.
module snn_frame_loader #(
  parameter int IMG_BITS    = 784,
  parameter int BYTE_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5_000_000,
  parameter int DIGIT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_rdy,
  input  logic [ADDR_W-1:0]  core_addr,
  output logic               core_q,
  output logic               core_start,
  input  logic               core_done,
  input  logic [DIGIT_W-1:0] core_digit,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_start,
  input  logic               tx_rdy,
  output logic [BYTE_W-1:0]  led,
  output logic               busy,
  output logic               frame_err,
  output logic               ovr_err
);

  localparam int BC_W = $clog2(BYTE_W + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, UNPACK, WAIT_BYTE, RUN, SEND} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wptr, wptr_n;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [BYTE_W-1:0] shift, shift_n;
  logic [BYTE_W-1:0] hold, hold_n;
  logic              hold_full, hold_full_n;
  logic [BYTE_W-1:0] result_n;
  logic              core_start_n, tx_start_n, frame_err_n, ovr_err_n;
  logic              wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              mem [2**ADDR_W];

  assign ram_addr = wr_en ? wptr : core_addr;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n      = state;
    wptr_n       = wptr;
    bit_cnt_n    = bit_cnt;
    to_cnt_n     = to_cnt;
    shift_n      = shift;
    hold_n       = hold;
    hold_full_n  = hold_full;
    result_n     = tx_data;
    core_start_n = 1'b0;
    tx_start_n   = 1'b0;
    frame_err_n  = 1'b0;
    ovr_err_n    = 1'b0;
    wr_en        = 1'b0;

    case (state)
      IDLE: begin
        if (rx_rdy) begin
          shift_n   = rx_data;
          bit_cnt_n = '0;
          state_n   = UNPACK;
        end
      end

      UNPACK: begin
        wr_en     = 1'b1;
        shift_n   = shift >> 1;
        wptr_n    = wptr + ADDR_W'(1);
        bit_cnt_n = bit_cnt + BC_W'(1);
        // A byte still pending when the last frame bit lands belongs to no frame and is dropped.
        if (wptr == ADDR_W'(IMG_BITS - 1)) begin
          wptr_n       = '0;
          bit_cnt_n    = '0;
          hold_full_n  = 1'b0;
          ovr_err_n    = hold_full | rx_rdy;
          core_start_n = 1'b1;
          state_n      = RUN;
        end else if (bit_cnt == BC_W'(BYTE_W - 1)) begin
          bit_cnt_n = '0;
          if (hold_full) begin
            shift_n     = hold;
            hold_full_n = 1'b0;
            ovr_err_n   = rx_rdy;
          end else if (rx_rdy) begin
            shift_n = rx_data;
          end else begin
            state_n = WAIT_BYTE;
          end
        end else if (rx_rdy) begin
          if (hold_full) begin
            ovr_err_n = 1'b1;
          end else begin
            hold_n      = rx_data;
            hold_full_n = 1'b1;
          end
        end
      end

      WAIT_BYTE: begin
        if (rx_rdy) begin
          shift_n  = rx_data;
          to_cnt_n = '0;
          state_n  = UNPACK;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          frame_err_n = 1'b1;
          wptr_n      = '0;
          bit_cnt_n   = '0;
          to_cnt_n    = '0;
          state_n     = IDLE;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end

      RUN: begin
        ovr_err_n = rx_rdy;
        if (core_done) begin
          result_n = BYTE_W'(core_digit);
          state_n  = SEND;
        end
      end

      SEND: begin
        ovr_err_n = rx_rdy;
        if (tx_rdy) begin
          tx_start_n = 1'b1;
          state_n    = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wptr       <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      core_q     <= 1'b0;
      core_start <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      led        <= '0;
      frame_err  <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      state      <= state_n;
      wptr       <= wptr_n;
      bit_cnt    <= bit_cnt_n;
      to_cnt     <= to_cnt_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      core_q     <= mem[ram_addr];
      core_start <= core_start_n;
      tx_data    <= result_n;
      tx_start   <= tx_start_n;
      led        <= result_n;
      frame_err  <= frame_err_n;
      ovr_err    <= ovr_err_n;
    end
  end

  // Input RAM contents survive reset; a new frame rewrites every pixel bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_addr] <= shift[0];
  end

endmodule
